// File: rtl/mem_arbiter_if.sv
// Request/done handshake of the fetch and memory stages plus the shared memory port.
// The arbiter connects through the slave modport; the pipeline and memory side use master.
interface mem_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          IReq;
  logic [AW-1:0] IAddr;
  logic          IFlush;
  logic          DRd;
  logic          DWr;
  logic [AW-1:0] DAddr;
  logic [DW-1:0] DWrData;
  logic          IDone;
  logic [DW-1:0] IData;
  logic          DDone;
  logic [DW-1:0] DData;
  logic          IStall;
  logic          DStall;
  logic          MemEn;
  logic          MemWr;
  logic [AW-1:0] MemAddr;
  logic [DW-1:0] MemWrData;
  logic          MemDone;
  logic [DW-1:0] MemRdData;
  logic          Err;

  modport slave (
    input  IReq, IAddr, IFlush, DRd, DWr, DAddr, DWrData, MemDone, MemRdData,
    output IDone, IData, DDone, DData, IStall, DStall,
    output MemEn, MemWr, MemAddr, MemWrData, Err
  );

  modport master (
    output IReq, IAddr, IFlush, DRd, DWr, DAddr, DWrData, MemDone, MemRdData,
    input  IDone, IData, DDone, DData, IStall, DStall,
    input  MemEn, MemWr, MemAddr, MemWrData, Err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one multi-cycle memory between fetch (I) and memory stage (D), D first,
// with fetch cancellation on flush and a sticky watchdog on memory responses.
module mem_arbiter #(
  parameter int AW      = 16,
  parameter int DW      = 16,
  parameter int TIMEOUT = 31
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, DBUSY, IBUSY} ArbState;

  ArbState       state;
  ArbState       stateNext;
  logic          memEn;
  logic          memWr;
  logic [AW-1:0] memAddr;
  logic [DW-1:0] memWrData;
  logic          dropFlag;
  logic [TW-1:0] timer;
  logic          err;
  logic          dReq;
  logic          grantD;
  logic          grantI;
  logic          leaveBusy;
  logic          timeoutHit;

  // State register; a reset mid-access simply abandons the transfer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Grant decisions in IDLE and exit conditions (completion or watchdog) while busy.
  always_comb begin
    stateNext  = state;
    dReq       = bus.DRd | bus.DWr;
    grantD     = 1'b0;
    grantI     = 1'b0;
    leaveBusy  = 1'b0;
    timeoutHit = 1'b0;
    unique case (state)
      IDLE: begin
        if (dReq) begin
          grantD    = 1'b1;
          stateNext = DBUSY;
        end else if (bus.IReq && !bus.IFlush) begin
          grantI    = 1'b1;
          stateNext = IBUSY;
        end
      end
      DBUSY, IBUSY: begin
        if (bus.MemDone) begin
          leaveBusy = 1'b1;
          stateNext = IDLE;
        end else if (timer == TW'(TIMEOUT)) begin
          leaveBusy  = 1'b1;
          timeoutHit = 1'b1;
          stateNext  = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Memory command registers, watchdog timer, flush drop flag and sticky error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      memEn     <= 1'b0;
      memWr     <= 1'b0;
      memAddr   <= '0;
      memWrData <= '0;
      dropFlag  <= 1'b0;
      timer     <= '0;
      err       <= 1'b0;
    end else begin
      memEn <= grantD | grantI;
      if (grantD) begin
        memWr     <= bus.DWr;
        memAddr   <= bus.DAddr;
        memWrData <= bus.DWrData;
      end else if (grantI) begin
        memWr   <= 1'b0;
        memAddr <= bus.IAddr;
      end
      if (grantD || grantI) begin
        timer <= '0;
      end else if (state != IDLE) begin
        timer <= timer + 1'b1;
      end
      if (timeoutHit) begin
        err <= 1'b1;
      end
      if (leaveBusy) begin
        dropFlag <= 1'b0;
      end else if (state == IBUSY && bus.IFlush) begin
        dropFlag <= 1'b1;
      end
    end
  end

  // A flushed fetch still completes at the memory, but its result never reaches the pipeline.
  assign bus.DDone     = (state == DBUSY) && bus.MemDone;
  assign bus.IDone     = (state == IBUSY) && bus.MemDone && !dropFlag && !bus.IFlush;
  assign bus.DData     = bus.DDone ? bus.MemRdData : '0;
  assign bus.IData     = bus.IDone ? bus.MemRdData : '0;
  assign bus.IStall    = bus.IReq & ~bus.IDone & ~bus.IFlush;
  assign bus.DStall    = (bus.DRd | bus.DWr) & ~bus.DDone;
  assign bus.MemEn     = memEn;
  assign bus.MemWr     = memWr;
  assign bus.MemAddr   = memAddr;
  assign bus.MemWrData = memWrData;
  assign bus.Err       = err;

endmodule
